// File: rtl/mips_pkg.sv
// Shared types for the MIPS core's multiply/divide unit.
//   mdu_op_t    : 3-bit operation code presented by execute
//   mdu_state_t : sequencing state of the iterative MDU
package mips_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_t;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_FIX  = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration of the MDU datapath.
//   is_div         : 1 = restoring trial-subtract, 0 = shift-add multiply
//   m              : multiplicand (multiply) or divisor (divide) magnitude
//   hi_in/lo_in    : partial product / partial remainder+dividend in
//   hi_out/lo_out  : same after retiring one bit
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] m,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        // multiply: add m when the multiplier LSB is set, then shift the
        // whole {carry, hi, lo} right; the multiplier drains out of lo
        sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, m} : '0);
        // divide: remainder < m, so 2*rem+bit fits in WIDTH+1 bits and
        // diff's MSB is a clean borrow flag
        shifted = {hi_in, lo_in[WIDTH-1]};
        diff    = shifted - {1'b0, m};
        if (is_div) begin
            if (!diff[WIDTH]) begin
                hi_out = diff[WIDTH-1:0];
                lo_out = {lo_in[WIDTH-2:0], 1'b1};
            end else begin
                hi_out = shifted[WIDTH-1:0];
                lo_out = {lo_in[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_out = sum[WIDTH:1];
            lo_out = {sum[0], lo_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO.
//   clk, rst (async, active-low)
//   start_e, op_e, src_a_e, src_b_e : instruction from execute
//   abort                            : cancel in-flight op
//   busy  : multi-cycle op in progress (state decode)
//   done  : one-cycle pulse after HI/LO written by a multi-cycle op
//   hi/lo : architectural registers
//
// state | meaning
// IDLE  | accept MTHI/MTLO (immediate) or start MULT/DIV
// CALC  | retire BITS_PER_CYCLE bits per cycle for N cycles
// FIX   | sign-correct and write HI/LO, pulse done
module mdu_iter
    import mips_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_e,
    input  mdu_op_t          op_e,
    input  logic [WIDTH-1:0] src_a_e,
    input  logic [WIDTH-1:0] src_b_e,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    mdu_state_t       state;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg_lo;
    logic             neg_hi;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] m;

    logic             signed_op, div_op, div_zero, sign_a, sign_b;
    logic [WIDTH-1:0] abs_a, abs_b, ld_m, ld_lo;
    logic             ld_neg_lo, ld_neg_hi;

    always_comb begin
        signed_op = (op_e == MDU_MULT) || (op_e == MDU_DIV);
        div_op    = (op_e == MDU_DIV) || (op_e == MDU_DIVU);
        div_zero  = div_op && (src_b_e == '0);
        sign_a    = signed_op && src_a_e[WIDTH-1];
        sign_b    = signed_op && src_b_e[WIDTH-1];
        abs_a     = sign_a ? -src_a_e : src_a_e;
        abs_b     = sign_b ? -src_b_e : src_b_e;
        ld_m      = div_op ? abs_b : abs_a;
        // with a zero divisor the raw dividend is fed through untouched so
        // the remainder comes out as src_a_e and the quotient as all ones
        ld_lo     = div_zero ? src_a_e : (div_op ? abs_a : abs_b);
        ld_neg_lo = !div_zero && (sign_a ^ sign_b);
        ld_neg_hi = div_op ? (!div_zero && sign_a) : (sign_a ^ sign_b);
    end

    // chained single-bit iterations
    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        logic [WIDTH-1:0] hi_in, lo_in, hi_out, lo_out;
        if (i == 0) begin : g_first
            assign hi_in = acc_hi;
            assign lo_in = acc_lo;
        end else begin : g_next
            assign hi_in = g_step[i-1].hi_out;
            assign lo_in = g_step[i-1].lo_out;
        end
        mdu_step #(.WIDTH(WIDTH)) u_step (
            .is_div (is_div),
            .m      (m),
            .hi_in  (hi_in),
            .lo_in  (lo_in),
            .hi_out (hi_out),
            .lo_out (lo_out)
        );
    end

    logic [WIDTH-1:0] step_hi, step_lo;
    assign step_hi = g_step[BITS_PER_CYCLE-1].hi_out;
    assign step_lo = g_step[BITS_PER_CYCLE-1].lo_out;

    // one negator per half; for a product the HI half takes the carry out
    // of the LO negation, for a divide the halves are independent
    logic             hi_cin;
    logic [WIDTH-1:0] neg_lo_v, neg_hi_v;
    always_comb begin
        hi_cin   = is_div ? 1'b1 : (acc_lo == '0);
        neg_lo_v = -acc_lo;
        neg_hi_v = ~acc_hi + WIDTH'(hi_cin);
    end

    assign busy = (state != MDU_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= MDU_IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            acc_hi <= '0;
            acc_lo <= '0;
            m      <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                MDU_IDLE: begin
                    if (start_e && !abort) begin
                        case (op_e)
                            MDU_MTHI: hi <= src_a_e;
                            MDU_MTLO: lo <= src_a_e;
                            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                                is_div <= div_op;
                                neg_lo <= ld_neg_lo;
                                neg_hi <= ld_neg_hi;
                                acc_hi <= '0;
                                acc_lo <= ld_lo;
                                m      <= ld_m;
                                cnt    <= CW'(N);
                                state  <= MDU_CALC;
                            end
                            default: ;
                        endcase
                    end
                end
                MDU_CALC: begin
                    if (abort) begin
                        state <= MDU_IDLE;
                    end else begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        cnt    <= cnt - CW'(1);
                        if (cnt == CW'(1)) state <= MDU_FIX;
                    end
                end
                MDU_FIX: begin
                    state <= MDU_IDLE;
                    if (!abort) begin
                        hi   <= neg_hi ? neg_hi_v : acc_hi;
                        lo   <= neg_lo ? neg_lo_v : acc_lo;
                        done <= 1'b1;
                    end
                end
                default: state <= MDU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: two 32-bit instances (1 and 4 bits/cycle) share one
// stimulus stream with hand-computed results; a 16-bit, 2 bits/cycle
// instance runs mixed ops against a behavioural arithmetic model.
module tb_mdu_iter;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_e = 1'b0;
    mdu_op_t     op_e = MDU_MULT;
    logic [31:0] src_a_e = '0;
    logic [31:0] src_b_e = '0;
    logic        abort = 1'b0;
    logic        busy0, busy1, done0, done1;
    logic [31:0] hi0, lo0, hi1, lo1;

    logic        start2 = 1'b0;
    mdu_op_t     op2 = MDU_MULT;
    logic [15:0] a2 = '0;
    logic [15:0] b2 = '0;
    logic        abort2 = 1'b0;
    logic        busy2, done2;
    logic [15:0] hi2, lo2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut0 (
        .clk(clk), .rst(rst), .start_e(start_e), .op_e(op_e), .src_a_e(src_a_e),
        .src_b_e(src_b_e), .abort(abort), .busy(busy0), .done(done0), .hi(hi0), .lo(lo0));

    mdu_iter #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut1 (
        .clk(clk), .rst(rst), .start_e(start_e), .op_e(op_e), .src_a_e(src_a_e),
        .src_b_e(src_b_e), .abort(abort), .busy(busy1), .done(done1), .hi(hi1), .lo(lo1));

    mdu_iter #(.WIDTH(16), .BITS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .rst(rst), .start_e(start2), .op_e(op2), .src_a_e(a2),
        .src_b_e(b2), .abort(abort2), .busy(busy2), .done(done2), .hi(hi2), .lo(lo2));

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic issue(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start_e = 1'b1; op_e = op; src_a_e = a; src_b_e = b;
        @(negedge clk);
        start_e = 1'b0;
    endtask

    task automatic run_cycles(input int n, output int nb0, output int nb1,
                              output int nd0, output int nd1);
        nb0 = 0; nb1 = 0; nd0 = 0; nd1 = 0;
        for (int i = 0; i < n; i++) begin
            if (busy0) nb0++;
            if (busy1) nb1++;
            if (done0) nd0++;
            if (done1) nd1++;
            @(negedge clk);
        end
    endtask

    task automatic do_op(input string tag, input mdu_op_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
        int nb0, nb1, nd0, nd1;
        issue(op, a, b);
        run_cycles(40, nb0, nb1, nd0, nd1);
        check({tag, ".hi_b1"}, hi0, exp_hi);
        check({tag, ".lo_b1"}, lo0, exp_lo);
        check({tag, ".hi_b4"}, hi1, exp_hi);
        check({tag, ".lo_b4"}, lo1, exp_lo);
        check({tag, ".busy_len_b1"}, nb0, 33);
        check({tag, ".busy_len_b4"}, nb1, 9);
        check({tag, ".done_cnt_b1"}, nd0, 1);
        check({tag, ".done_cnt_b4"}, nd1, 1);
    endtask

    function automatic logic [31:0] ref16(input mdu_op_t op, input logic [15:0] a,
                                          input logic [15:0] b);
        int sa, sb;
        logic [31:0] r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r = '0;
        case (op)
            MDU_MULT:  r = 32'(sa * sb);
            MDU_MULTU: r = {16'b0, a} * {16'b0, b};
            MDU_DIV:   r = (b == 16'd0) ? {a, 16'hFFFF} : {16'(sa % sb), 16'(sa / sb)};
            MDU_DIVU:  r = (b == 16'd0) ? {a, 16'hFFFF} : {a % b, a / b};
            default:   r = '0;
        endcase
        return r;
    endfunction

    task automatic op16(input string tag, input mdu_op_t op, input logic [15:0] a,
                        input logic [15:0] b);
        int nb, nd;
        logic [31:0] exp;
        exp = ref16(op, a, b);
        @(negedge clk);
        start2 = 1'b1; op2 = op; a2 = a; b2 = b;
        @(negedge clk);
        start2 = 1'b0;
        nb = 0; nd = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy2) nb++;
            if (done2) nd++;
            @(negedge clk);
        end
        check({tag, ".hi"}, hi2, exp[31:16]);
        check({tag, ".lo"}, lo2, exp[15:0]);
        check({tag, ".busy_len"}, nb, 9);
        check({tag, ".done_cnt"}, nd, 1);
    endtask

    initial begin
        int nb0, nb1, nd0, nd1;
        mdu_op_t rop;
        logic [15:0] ra, rb;

        repeat (2) @(negedge clk);
        check("reset.hi", hi0, 0);
        check("reset.lo", lo0, 0);
        check("reset.busy", busy0, 0);
        check("reset.done", done0, 0);
        rst = 1'b1;

        do_op("mult_m3x5",   MDU_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1);
        do_op("divu_100_7",  MDU_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E);
        do_op("div_m7_2",    MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("div_7_m2",    MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        do_op("multu_max",   MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        do_op("mult_carry",  MDU_MULT,  32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        do_op("mult_minmin", MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        do_op("div_by_zero", MDU_DIV,   32'h0000_002A, 32'd0,         32'h0000_002A, 32'hFFFF_FFFF);
        do_op("div_min_m1",  MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // MTHI then MTLO on consecutive cycles
        @(negedge clk);
        start_e = 1'b1; op_e = MDU_MTHI; src_a_e = 32'h1234_5678;
        @(negedge clk);
        check("mthi.hi", hi0, 32'h1234_5678);
        check("mthi.busy", busy0, 0);
        op_e = MDU_MTLO; src_a_e = 32'h9ABC_DEF0;
        @(negedge clk);
        start_e = 1'b0;
        check("mtlo.lo", lo0, 32'h9ABC_DEF0);
        check("mtlo.hi_kept", hi0, 32'h1234_5678);
        check("mtlo.busy", busy1, 0);

        // MTHI arriving mid-calculation is dropped
        issue(MDU_MULTU, 32'd3, 32'd4);
        repeat (3) @(negedge clk);
        issue(MDU_MTHI, 32'hDEAD_BEEF, 32'd0);
        run_cycles(40, nb0, nb1, nd0, nd1);
        check("mthi_busy.hi_b1", hi0, 32'd0);
        check("mthi_busy.lo_b1", lo0, 32'd12);
        check("mthi_busy.hi_b4", hi1, 32'd0);

        // abort mid-CALC: registers keep 0 / 12, no done
        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort.busy_b1", busy0, 0);
        check("abort.busy_b4", busy1, 0);
        run_cycles(40, nb0, nb1, nd0, nd1);
        check("abort.done_b1", nd0, 0);
        check("abort.done_b4", nd1, 0);
        check("abort.hi", hi0, 32'd0);
        check("abort.lo", lo0, 32'd12);

        // abort in IDLE wins over start
        @(negedge clk);
        start_e = 1'b1; op_e = MDU_MULT; src_a_e = 32'd2; src_b_e = 32'd3; abort = 1'b1;
        @(negedge clk);
        start_e = 1'b0; abort = 1'b0;
        check("abort_idle.busy", busy0, 0);
        run_cycles(5, nb0, nb1, nd0, nd1);
        check("abort_idle.lo", lo0, 32'd12);

        // asynchronous reset mid-CALC
        issue(MDU_MTHI, 32'h0000_55AA, 32'd0);
        issue(MDU_MULTU, 32'd3, 32'd4);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst.hi", hi0, 0);
        check("async_rst.lo", lo0, 0);
        check("async_rst.busy_b1", busy0, 0);
        check("async_rst.busy_b4", busy1, 0);
        @(negedge clk);
        rst = 1'b1;

        // 16-bit, 2 bits/cycle instance against the arithmetic model
        op16("w16.min_m1", MDU_DIV,  16'h8000, 16'hFFFF);
        op16("w16.mult",   MDU_MULT, 16'hFFF0, 16'h0123);
        op16("w16.div0",   MDU_DIV,  16'h8001, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            rop = mdu_op_t'($urandom_range(0, 3));
            ra  = 16'($urandom);
            rb  = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
            op16($sformatf("w16.rand%0d", i), rop, ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
